rps_round_controller: RTL and testbench

- Match-level controller for the rock-paper-scissors game. It is the initiating end of the round-timer interface.
- Per round it clears and starts the external one-shot timer and collects one locked move per player until the timer expires or both players have locked.
- It judges the round, keeps the scores and declares the match winner.
- Sits between the debounced player-input logic and the display/score logic.

---
 rtl/rps_round_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_rps_round_controller.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rps_round_controller.sv
// Rock-paper-scissors match controller: runs each round against an external one-shot timer, judges it and keeps score.
// Optional macro TIE_AUTO_REPLAY_EN: a tie round restarts immediately (JUDGE -> CLEAR) without start_btn.
module rps_round_controller #(
    parameter int unsigned WINS_NEEDED = 2,
    parameter int unsigned SCORE_W     = 3,
    parameter int unsigned ARM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_btn,
    input  logic [1:0]         p1_move,
    input  logic               p1_lock,
    input  logic [1:0]         p2_move,
    input  logic               p2_lock,
    output logic               timer_clr,
    output logic               timer_in,
    input  logic               timer_hit,
    output logic [1:0]         round_result,
    output logic               result_valid,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               match_over,
    output logic               fault
);

    localparam logic [1:0] MOVE_NONE     = 2'b00;
    localparam logic [1:0] MOVE_ROCK     = 2'b01;
    localparam logic [1:0] MOVE_PAPER    = 2'b10;
    localparam logic [1:0] MOVE_SCISSORS = 2'b11;

    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_P1   = 2'b01;
    localparam logic [1:0] RES_P2   = 2'b10;
    localparam logic [1:0] RES_TIE  = 2'b11;

    localparam logic [SCORE_W-1:0] WINS_LIM = SCORE_W'(WINS_NEEDED);

    localparam int unsigned ARM_W = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT) : 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARM,
        RUN,
        JUDGE,
        DONE,
        FAULT
    } state_t;

    state_t state, next_state;

    logic [1:0]         m1, m2;
    logic               locked1, locked2;
    logic [ARM_W-1:0]   arm_cnt;
    logic [SCORE_W-1:0] score1, score2;
    logic [1:0]         result_hold;

    logic               take1, take2, both_locked;
    logic [1:0]         verdict;
    logic [SCORE_W-1:0] score1_inc, score2_inc;
    logic               final_round;

    // First lock per player in RUN only; later locks in the round are dropped.
    always_comb begin
        take1       = (state == RUN) && p1_lock && !locked1;
        take2       = (state == RUN) && p2_lock && !locked2;
        both_locked = (locked1 || take1) && (locked2 || take2);
    end

    always_comb begin
        verdict = RES_TIE;
        if (m1 == MOVE_NONE && m2 == MOVE_NONE) begin
            verdict = RES_TIE;
        end else if (m1 == MOVE_NONE) begin
            verdict = RES_P2;
        end else if (m2 == MOVE_NONE) begin
            verdict = RES_P1;
        end else if (m1 == m2) begin
            verdict = RES_TIE;
        end else if ((m1 == MOVE_ROCK     && m2 == MOVE_SCISSORS) ||
                     (m1 == MOVE_SCISSORS && m2 == MOVE_PAPER)    ||
                     (m1 == MOVE_PAPER    && m2 == MOVE_ROCK)) begin
            verdict = RES_P1;
        end else begin
            verdict = RES_P2;
        end
    end

    always_comb begin
        score1_inc  = (score1 >= WINS_LIM) ? WINS_LIM : score1 + 1'b1;
        score2_inc  = (score2 >= WINS_LIM) ? WINS_LIM : score2 + 1'b1;
        final_round = ((verdict == RES_P1) && (score1_inc == WINS_LIM)) ||
                      ((verdict == RES_P2) && (score2_inc == WINS_LIM));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state   = state;
        timer_clr    = 1'b0;
        timer_in     = 1'b0;
        result_valid = 1'b0;
        match_over   = 1'b0;
        fault        = 1'b0;
        round_result = result_hold;
        unique case (state)
            IDLE: begin
                if (start_btn) next_state = CLEAR;
            end
            CLEAR: begin
                timer_clr  = 1'b1;
                next_state = ARM;
            end
            ARM: begin
                timer_in = 1'b1;
                if (!timer_hit) begin
                    next_state = RUN;
                end else if (arm_cnt == ARM_LAST) begin
                    next_state = FAULT;
                end
            end
            RUN: begin
                if (timer_hit || both_locked) next_state = JUDGE;
            end
            JUDGE: begin
                result_valid = 1'b1;
                round_result = verdict;
`ifdef TIE_AUTO_REPLAY_EN
                if (verdict == RES_TIE) begin
                    next_state = CLEAR;
                end else if (final_round) begin
                    next_state = DONE;
                end else begin
                    next_state = IDLE;
                end
`else
                next_state = final_round ? DONE : IDLE;
`endif
            end
            DONE: begin
                match_over = 1'b1;
                if (start_btn) next_state = CLEAR;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m1      <= MOVE_NONE;
            m2      <= MOVE_NONE;
            locked1 <= 1'b0;
            locked2 <= 1'b0;
        end else if (state == CLEAR) begin
            m1      <= MOVE_NONE;
            m2      <= MOVE_NONE;
            locked1 <= 1'b0;
            locked2 <= 1'b0;
        end else begin
            if (take1) begin
                m1      <= p1_move;
                locked1 <= 1'b1;
            end
            if (take2) begin
                m2      <= p2_move;
                locked2 <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            arm_cnt <= '0;
        end else if (state == ARM) begin
            if (timer_hit) arm_cnt <= arm_cnt + 1'b1;
        end else begin
            arm_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score1 <= '0;
            score2 <= '0;
        end else if (state == JUDGE) begin
            if (verdict == RES_P1) score1 <= score1_inc;
            if (verdict == RES_P2) score2 <= score2_inc;
        end else if (state == DONE && start_btn) begin
            score1 <= '0;
            score2 <= '0;
        end
    end

    // Clearing on entry makes round_result read 00 during the CLEAR cycle itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_hold <= RES_NONE;
        end else if (next_state == CLEAR) begin
            result_hold <= RES_NONE;
        end else if (state == JUDGE) begin
            result_hold <= verdict;
        end
    end

    assign p1_score = score1;
    assign p2_score = score2;

endmodule

// File: tb/tb_rps_round_controller.sv
// Self-checking bench for rps_round_controller with a behavioural round-timer model and a game-rule reference model.
// Honours TIE_AUTO_REPLAY_EN when defined for the build.
module tb_rps_round_controller;

    localparam int WINS = 2;
    localparam int SW   = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start_btn = 1'b0;
    logic [1:0]    p1_move = 2'b00;
    logic          p1_lock = 1'b0;
    logic [1:0]    p2_move = 2'b00;
    logic          p2_lock = 1'b0;
    logic          timer_clr, timer_in, timer_hit;
    logic [1:0]    round_result;
    logic          result_valid;
    logic [SW-1:0] p1_score, p2_score;
    logic          match_over, fault;

    int checks = 0;
    int passes = 0;

    // reference game state
    int s1 = 0, s2 = 0;
    bit over = 0;
    bit in_clear = 0;

    // timer model controls
    bit hold_hit = 0;
    int drop_delay = 3;
    int run_len = 20;
    int tphase = 0;
    int tcnt = 0;

    rps_round_controller #(
        .WINS_NEEDED(WINS),
        .SCORE_W(SW),
        .ARM_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start_btn(start_btn),
        .p1_move(p1_move),
        .p1_lock(p1_lock),
        .p2_move(p2_move),
        .p2_lock(p2_lock),
        .timer_clr(timer_clr),
        .timer_in(timer_in),
        .timer_hit(timer_hit),
        .round_result(round_result),
        .result_valid(result_valid),
        .p1_score(p1_score),
        .p2_score(p2_score),
        .match_over(match_over),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // One-shot timer: idle/expired => hit=1; drops hit drop_delay cycles after start, expires run_len cycles later.
    always @(posedge clk) begin
        #2;
        if (!reset || hold_hit || timer_clr) begin
            timer_hit = 1'b1;
            tphase = 0;
        end else begin
            case (tphase)
                0: if (timer_in) begin tphase = 1; tcnt = drop_delay; end
                1: begin
                    tcnt--;
                    if (tcnt <= 0) begin timer_hit = 1'b0; tphase = 2; tcnt = run_len; end
                end
                default: begin
                    tcnt--;
                    if (tcnt <= 0) begin timer_hit = 1'b1; tphase = 0; end
                end
            endcase
        end
    end

    function automatic logic [1:0] ref_judge(input int a, input int b);
        if (a == 0 && b == 0) return 2'b11;
        if (a == 0) return 2'b10;
        if (b == 0) return 2'b01;
        if (a == b) return 2'b11;
        return (((a - b + 3) % 3) == 1) ? 2'b01 : 2'b10;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        start_btn = 1'b0; p1_lock = 1'b0; p2_lock = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        s1 = 0; s2 = 0; over = 0; in_clear = 0;
    endtask

    // One full round; *_at are RUN-cycle indices of lock pulses (-1 = never).
    task automatic play_round(input int p1_at, input logic [1:0] m1, input int p2_at, input logic [1:0] m2,
                              input int p2b_at, input logic [1:0] m2b, input int rlen,
                              input bit mid_start, input bit stray);
        int k;
        bit l1, l2, done;
        logic [1:0] e1, e2, exp_r;
        l1 = 0; l2 = 0; e1 = 2'b00; e2 = 2'b00; done = 0;
        run_len = rlen;
        if (!in_clear) begin
            start_btn = 1'b1;
            @(negedge clk);
            start_btn = 1'b0;
        end
        in_clear = 0;
        if (over) begin s1 = 0; s2 = 0; over = 0; end
        checks++;
        if (timer_clr !== 1'b1 || timer_in !== 1'b0)
            $display("FAIL clear_pulse: timer_clr=%b timer_in=%b want 1/0", timer_clr, timer_in);
        else passes++;
        checks++;
        if (round_result !== 2'b00 || p1_score !== SW'(s1) || p2_score !== SW'(s2) || match_over !== 1'b0)
            $display("FAIL clear_state: result=%b scores=%0d/%0d over=%b want 00 %0d/%0d 0",
                     round_result, p1_score, p2_score, match_over, s1, s2);
        else passes++;
        @(negedge clk);
        checks++;
        if (timer_in !== 1'b1 || timer_clr !== 1'b0)
            $display("FAIL arm_start: timer_in=%b timer_clr=%b want 1/0", timer_in, timer_clr);
        else passes++;
        if (stray) begin
            p1_lock = 1'b1; p1_move = 2'b11; p2_lock = 1'b1; p2_move = 2'b11;
        end
        k = 0;
        while (timer_in === 1'b1 && k < 40) begin
            @(negedge clk);
            p1_lock = 1'b0; p2_lock = 1'b0;
            k++;
        end
        checks++;
        if (timer_in !== 1'b0) begin
            $display("FAIL arm_wait: timer_in=%b still high after %0d cycles, want 0", timer_in, k);
            return;
        end else passes++;
        k = 0;
        while (!done && k < 80) begin
            checks++;
            if (timer_in !== 1'b0 || timer_clr !== 1'b0 || result_valid !== 1'b0)
                $display("FAIL run_cycle%0d: in=%b clr=%b valid=%b want 0/0/0", k, timer_in, timer_clr, result_valid);
            else passes++;
            p1_move = m1;
            p2_move = (k == p2b_at) ? m2b : m2;
            p1_lock = (k == p1_at);
            p2_lock = (k == p2_at) || (k == p2b_at);
            start_btn = mid_start && (k == 1);
            if (p1_lock && !l1) begin l1 = 1; e1 = p1_move; end
            if (p2_lock && !l2) begin l2 = 1; e2 = p2_move; end
            done = (l1 && l2) || (timer_hit === 1'b1);
            @(negedge clk);
            p1_lock = 1'b0; p2_lock = 1'b0; start_btn = 1'b0;
            k++;
        end
        exp_r = ref_judge(int'(e1), int'(e2));
        checks++;
        if (result_valid !== 1'b1 || round_result !== exp_r)
            $display("FAIL judge: valid=%b result=%b want 1 %b", result_valid, round_result, exp_r);
        else passes++;
        checks++;
        if (p1_score !== SW'(s1) || p2_score !== SW'(s2))
            $display("FAIL score_early: %0d/%0d want %0d/%0d", p1_score, p2_score, s1, s2);
        else passes++;
        if (exp_r == 2'b01 && s1 < WINS) s1++;
        if (exp_r == 2'b10 && s2 < WINS) s2++;
        over = (s1 == WINS) || (s2 == WINS);
        @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || p1_score !== SW'(s1) || p2_score !== SW'(s2) || match_over !== over)
            $display("FAIL post_judge: valid=%b scores=%0d/%0d over=%b want 0 %0d/%0d %b",
                     result_valid, p1_score, p2_score, match_over, s1, s2, over);
        else passes++;
`ifdef TIE_AUTO_REPLAY_EN
        if (exp_r == 2'b11) begin
            checks++;
            if (timer_clr !== 1'b1 || round_result !== 2'b00)
                $display("FAIL tie_replay: timer_clr=%b result=%b want 1 00", timer_clr, round_result);
            else passes++;
            in_clear = 1;
        end else begin
            checks++;
            if (timer_clr !== 1'b0 || round_result !== exp_r)
                $display("FAIL result_hold: timer_clr=%b result=%b want 0 %b", timer_clr, round_result, exp_r);
            else passes++;
        end
`else
        checks++;
        if (timer_clr !== 1'b0 || round_result !== exp_r)
            $display("FAIL result_hold: timer_clr=%b result=%b want 0 %b", timer_clr, round_result, exp_r);
        else passes++;
        @(negedge clk);
        checks++;
        if (timer_clr !== 1'b0 || timer_in !== 1'b0 || round_result !== exp_r)
            $display("FAIL idle_hold: clr=%b in=%b result=%b want 0 0 %b", timer_clr, timer_in, round_result, exp_r);
        else passes++;
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({timer_clr, timer_in, round_result, result_valid, p1_score, p2_score, match_over, fault} !== '0)
            $display("FAIL reset_outputs: clr=%b in=%b res=%b valid=%b s=%0d/%0d over=%b fault=%b want all 0",
                     timer_clr, timer_in, round_result, result_valid, p1_score, p2_score, match_over, fault);
        else passes++;
        do_reset();
        @(negedge clk);
        checks++;
        if (timer_clr !== 1'b0 || timer_in !== 1'b0 || fault !== 1'b0)
            $display("FAIL reset_idle: clr=%b in=%b fault=%b want 0/0/0", timer_clr, timer_in, fault);
        else passes++;
    endtask

    task automatic test_early_finish();
        drop_delay = 3;
        play_round(0, 2'b01, 2, 2'b11, -1, 2'b00, 30, 0, 0);
    endtask

    task automatic test_no_locks();
        play_round(-1, 2'b00, -1, 2'b00, -1, 2'b00, 20, 0, 0);
    endtask

    task automatic test_p2_only();
        play_round(-1, 2'b00, 1, 2'b10, 3, 2'b01, 8, 0, 1);
    endtask

    task automatic test_match();
        do_reset();
        play_round(1, 2'b10, 2, 2'b01, -1, 2'b00, 15, 0, 0);
        play_round(0, 2'b11, 4, 2'b10, -1, 2'b00, 15, 1, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (match_over !== 1'b1 || p1_score !== SW'(WINS) || timer_clr !== 1'b0)
            $display("FAIL done_hold: over=%b p1=%0d clr=%b want 1 %0d 0", match_over, p1_score, timer_clr, WINS);
        else passes++;
        play_round(3, 2'b01, 1, 2'b10, -1, 2'b00, 12, 0, 0);
    endtask

    task automatic test_tie();
        play_round(1, 2'b10, 1, 2'b10, -1, 2'b00, 12, 0, 0);
        play_round(0, 2'b11, 2, 2'b01, -1, 2'b00, 12, 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 30; r++) begin
            int a1, a2, a2b;
            a1  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 10));
            a2  = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 10));
            a2b = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
            drop_delay = $urandom_range(1, 6);
            play_round(a1, 2'($urandom_range(1, 3)), a2, 2'($urandom_range(1, 3)), a2b, 2'($urandom_range(1, 3)),
                       $urandom_range(2, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_fault();
        do_reset();
        hold_hit = 1;
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        checks++;
        if (timer_clr !== 1'b1)
            $display("FAIL fault_clear: timer_clr=%b want 1", timer_clr);
        else passes++;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (fault !== 1'b0 || timer_in !== 1'b1)
                $display("FAIL arm_cycle%0d: fault=%b timer_in=%b want 0 1", i, fault, timer_in);
            else passes++;
        end
        @(negedge clk);
        checks++;
        if (fault !== 1'b1 || timer_in !== 1'b0)
            $display("FAIL fault_entry: fault=%b timer_in=%b want 1 0", fault, timer_in);
        else passes++;
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        @(negedge clk);
        checks++;
        if (fault !== 1'b1 || timer_clr !== 1'b0)
            $display("FAIL fault_sticky: fault=%b timer_clr=%b want 1 0", fault, timer_clr);
        else passes++;
        hold_hit = 0;
        do_reset();
        checks++;
        if (fault !== 1'b0)
            $display("FAIL fault_reset: fault=%b want 0", fault);
        else passes++;
    endtask

    task automatic test_async_reset();
        int k;
        do_reset();
        drop_delay = 2;
        play_round(0, 2'b01, 1, 2'b11, -1, 2'b00, 20, 0, 0);
        start_btn = 1'b1;
        @(negedge clk);
        start_btn = 1'b0;
        k = 0;
        while (timer_in !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        while (timer_in === 1'b1 && k < 40) begin @(negedge clk); k++; end
        p1_move = 2'b10; p1_lock = 1'b1;
        @(negedge clk);
        p1_lock = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({timer_clr, timer_in, round_result, result_valid, p1_score, p2_score, match_over, fault} !== '0)
            $display("FAIL async_reset: clr=%b in=%b res=%b valid=%b s=%0d/%0d over=%b fault=%b want all 0",
                     timer_clr, timer_in, round_result, result_valid, p1_score, p2_score, match_over, fault);
        else passes++;
        @(negedge clk);
        reset = 1'b1;
        s1 = 0; s2 = 0; over = 0; in_clear = 0;
    endtask

    initial begin
        test_reset();
        test_early_finish();
        test_no_locks();
        test_p2_only();
        test_match();
        test_tie();
        test_random();
        test_fault();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
